// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step and fetch-action encodings.
// The hazard staller and the downstream stages use the same encodings.
package pipe_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_SQUASH = 2'b10,
    ST_REDIR  = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_INCR = 2'b00,
    PC_HOLD = 2'b01,
    PC_LOAD = 2'b10
  } pc_op_e;

endpackage

// File: rtl/if_stage_ctrl_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// The master side drives the hazard, redirect and memory-data inputs; the slave side is the fetch stage.
interface if_stage_ctrl_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 8
);
  logic               stall_J;
  logic               stall_B;
  logic               stall_RAW;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;
  logic [1:0]         fsm_state;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall_J, stall_B, stall_RAW, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, fsm_state, bubble_cnt
  );

  modport slave (
    input  stall_J, stall_B, stall_RAW, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, fsm_state, bubble_cnt
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter: async reset to RESET_PC, then load / hold / increment by priority of op_i.
// Loaded targets are word-aligned by clearing the two low bits.
module pc_reg
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  pc_op_e          op_i,
  input  logic [PC_W-1:0] load_pc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (op_i)
      PC_LOAD: pc_d = {load_pc_i[PC_W-1:2], 2'b00};
      PC_INCR: pc_d = pc_q + PC_W'(PC_INC);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch stage with IF/ID register: picks one action per edge (redirect > squash > hold > run),
// drives the instruction address from the PC and counts injected bubbles.
module if_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  if_stage_ctrl_if.slave  bus
);

  fetch_state_e       state_q, state_d;
  pc_op_e             pc_op;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .op_i      (pc_op),
    .load_pc_i (bus.redirect_pc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d = ST_RUN;
    pc_op   = PC_INCR;
    if (bus.redirect_valid) begin
      state_d = ST_REDIR;
      pc_op   = PC_LOAD;
    end else if (bus.stall_J || bus.stall_B) begin
      state_d = ST_SQUASH;
      pc_op   = PC_HOLD;
    end else if (bus.stall_RAW) begin
      state_d = ST_HOLD;
      pc_op   = PC_HOLD;
    end
  end

  // A bubble looks exactly like the post-reset IF/ID contents: NOP at PC 0, not valid.
  always_comb begin
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    bubble_d  = bubble_q;
    unique case (state_d)
      ST_REDIR, ST_SQUASH: begin
        instr_d   = INSTR_W'(NOP);
        ifid_pc_d = '0;
        valid_d   = 1'b0;
        if (!(&bubble_q)) bubble_d = bubble_q + 1'b1;
      end
      ST_RUN: begin
        instr_d   = bus.imem_rdata;
        ifid_pc_d = pc;
        valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      instr_q   <= INSTR_W'(NOP);
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
      bubble_q  <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      bubble_q  <= bubble_d;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.fsm_state  = state_q;
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: two instances (reset PC 0 and 0xFFFF_FFF8) driven by the same stimulus,
// a per-cycle compare against a behavioural model plus hand-computed checkpoints.
module tb_if_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errorCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  if_stage_ctrl_if #(.PC_W(32), .INSTR_W(32), .CNT_W(8)) busA ();
  if_stage_ctrl_if #(.PC_W(32), .INSTR_W(32), .CNT_W(8)) busB ();

  // Instruction memory returns 0x1000 + address for both instances.
  assign busA.imem_rdata     = 32'h1000 + busA.imem_addr;
  assign busB.imem_rdata     = 32'h1000 + busB.imem_addr;
  assign busB.stall_J        = busA.stall_J;
  assign busB.stall_B        = busA.stall_B;
  assign busB.stall_RAW      = busA.stall_RAW;
  assign busB.redirect_valid = busA.redirect_valid;
  assign busB.redirect_pc    = busA.redirect_pc;

  if_stage_ctrl #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .CNT_W(8)) dutA (
    .clk_i (clk), .rst_ni (rst_n), .bus (busA)
  );

  if_stage_ctrl #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .CNT_W(8)) dutB (
    .clk_i (clk), .rst_ni (rst_n), .bus (busB)
  );

  logic [31:0] resetPc [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] mPc     [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] mInstr  [2] = '{32'h0, 32'h0};
  logic [31:0] mIfPc   [2] = '{32'h0, 32'h0};
  logic        mValid  [2] = '{1'b0, 1'b0};
  int          mAction [2] = '{0, 0};
  int          mBubbles[2] = '{0, 0};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: action codes 0 run, 1 hold, 2 squash, 3 redirect; bubbles saturate at 255.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mPc[i] = resetPc[i]; mInstr[i] = 0; mIfPc[i] = 0; mValid[i] = 0;
        mAction[i] = 0; mBubbles[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busA.redirect_valid || busA.stall_J || busA.stall_B) begin
          mAction[i] = busA.redirect_valid ? 3 : 2;
          if (busA.redirect_valid) mPc[i] = busA.redirect_pc - (busA.redirect_pc % 4);
          mInstr[i] = 0; mIfPc[i] = 0; mValid[i] = 0;
          mBubbles[i] = (mBubbles[i] >= 255) ? 255 : mBubbles[i] + 1;
        end else if (busA.stall_RAW) begin
          mAction[i] = 1;
        end else begin
          mAction[i] = 0;
          mInstr[i] = 32'h1000 + mPc[i];
          mIfPc[i] = mPc[i];
          mValid[i] = 1;
          mPc[i] = mPc[i] + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("addrA",   busA.imem_addr,         mPc[0]);
    checkOutput("instrA",  busA.ifid_instr,        mInstr[0]);
    checkOutput("ifpcA",   busA.ifid_pc,           mIfPc[0]);
    checkOutput("validA",  32'(busA.ifid_valid),   32'(mValid[0]));
    checkOutput("stateA",  32'(busA.fsm_state),    32'(mAction[0]));
    checkOutput("bubbleA", 32'(busA.bubble_cnt),   32'(mBubbles[0]));
    checkOutput("addrB",   busB.imem_addr,         mPc[1]);
    checkOutput("instrB",  busB.ifid_instr,        mInstr[1]);
    checkOutput("ifpcB",   busB.ifid_pc,           mIfPc[1]);
    checkOutput("validB",  32'(busB.ifid_valid),   32'(mValid[1]));
    checkOutput("bubbleB", 32'(busB.bubble_cnt),   32'(mBubbles[1]));
  end

  task automatic applyStimulus(input logic j, input logic b, input logic raw,
                               input logic rv, input logic [31:0] rpc, input int cycles);
    busA.stall_J        = j;
    busA.stall_B        = b;
    busA.stall_RAW      = raw;
    busA.redirect_valid = rv;
    busA.redirect_pc    = rpc;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin
    busA.stall_J = 0; busA.stall_B = 0; busA.stall_RAW = 0;
    busA.redirect_valid = 0; busA.redirect_pc = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    checkOutput("rst_addrA",  busA.imem_addr,        32'h0);
    checkOutput("rst_addrB",  busB.imem_addr,        32'hFFFF_FFF8);
    checkOutput("rst_validA", 32'(busA.ifid_valid),  32'h0);
    checkOutput("rst_instrA", busA.ifid_instr,       32'h0);
    checkOutput("rst_stateA", 32'(busA.fsm_state),   32'h0);
    checkOutput("rst_bubA",   32'(busA.bubble_cnt),  32'h0);

    // Idle fetches, plus PC wrap on the high-reset instance.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("run_ifpc",  busA.ifid_pc,          32'((k - 1) * 4));
      checkOutput("run_instr", busA.ifid_instr,       32'(32'h1000 + (k - 1) * 4));
      checkOutput("run_valid", 32'(busA.ifid_valid),  32'h1);
      if (k == 1) checkOutput("wrap_addr1", busB.imem_addr, 32'hFFFF_FFFC);
      if (k == 2) checkOutput("wrap_addr2", busB.imem_addr, 32'h0000_0000);
    end
    checkOutput("run_addr4", busA.imem_addr, 32'h10);

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 2);
    checkOutput("pre_raw_addr", busA.imem_addr, 32'h8);

    applyStimulus(0, 0, 1, 0, 0, 3);
    checkOutput("raw_addr",  busA.imem_addr,         32'h8);
    checkOutput("raw_ifpc",  busA.ifid_pc,           32'h4);
    checkOutput("raw_valid", 32'(busA.ifid_valid),   32'h1);
    checkOutput("raw_state", 32'(busA.fsm_state),    32'h1);
    checkOutput("raw_bub",   32'(busA.bubble_cnt),   32'h0);

    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("run_addrC", busA.imem_addr, 32'hC);

    for (int k = 1; k <= 2; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("sqB_valid", 32'(busA.ifid_valid),  32'h0);
      checkOutput("sqB_instr", busA.ifid_instr,       32'h0);
      checkOutput("sqB_addr",  busA.imem_addr,        32'hC);
      checkOutput("sqB_state", 32'(busA.fsm_state),   32'h2);
    end
    checkOutput("sqB_bub", 32'(busA.bubble_cnt), 32'h2);

    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("holdbub_valid", 32'(busA.ifid_valid), 32'h0);
    checkOutput("holdbub_bub",   32'(busA.bubble_cnt), 32'h2);

    applyStimulus(0, 0, 1, 1, 32'h203, 1);
    checkOutput("redir_addr",  busA.imem_addr,        32'h200);
    checkOutput("redir_valid", 32'(busA.ifid_valid),  32'h0);
    checkOutput("redir_state", 32'(busA.fsm_state),   32'h3);

    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("postredir_ifpc",  busA.ifid_pc,    32'h200);
    checkOutput("postredir_instr", busA.ifid_instr, 32'h1200);
    checkOutput("postredir_addr",  busA.imem_addr,  32'h204);

    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
                    ($urandom % 10) == 0, $urandom, 1);
    end

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 300);
    checkOutput("sat_bubA", 32'(busA.bubble_cnt), 32'd255);
    checkOutput("sat_bubB", 32'(busB.bubble_cnt), 32'd255);

    // Reset pulse mid-cycle with a redirect pending: everything clears before the next edge.
    busA.stall_J = 0;
    busA.redirect_valid = 1;
    busA.redirect_pc = 32'h400;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_addrA", busA.imem_addr,        32'h0);
    checkOutput("mid_addrB", busB.imem_addr,        32'hFFFF_FFF8);
    checkOutput("mid_instr", busA.ifid_instr,       32'h0);
    checkOutput("mid_ifpc",  busA.ifid_pc,          32'h0);
    checkOutput("mid_valid", 32'(busA.ifid_valid),  32'h0);
    checkOutput("mid_state", 32'(busA.fsm_state),   32'h0);
    checkOutput("mid_bub",   32'(busA.bubble_cnt),  32'h0);
    rst_n = 1'b1;
    busA.redirect_valid = 0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("after_rst_ifpc", busA.ifid_pc,   32'h0);
    checkOutput("after_rst_addr", busA.imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
